victim_writeback_buffer: RTL



---
 rtl/vwb_pkg.sv | 23 ++
 rtl/vwb_match_unit.sv | 31 +++
 rtl/victim_writeback_buffer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/vwb_pkg.sv
// rtl/vwb_pkg.sv - shared types and constants for the victim writeback buffer
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package vwb_pkg;

  typedef enum logic {VWB_IDLE, VWB_SEND} vwb_state_t;

  localparam int VWB_ADDR_WIDTH         = `ADDR_WIDTH;
  localparam int VWB_DATA_WIDTH         = `DATA_WIDTH;
  localparam int VWB_BLOCK_OFFSET_WIDTH = 2;
  // Line address drops the word-in-line and byte-in-word bits.
  localparam int VWB_LINE_ADDR_WIDTH    = `ADDR_WIDTH - VWB_BLOCK_OFFSET_WIDTH - 2;

  function automatic int vwb_line_size(input int block_offset_width);
    return 1 << block_offset_width;
  endfunction

endpackage

// File: rtl/vwb_match_unit.sv
// rtl/vwb_match_unit.sv - DEPTH-way tag compare with youngest-first select
module vwb_match_unit #(
  parameter int DEPTH       = 4,
  parameter int DEPTH_WIDTH = 2,
  parameter int TAG_WIDTH   = 28
) (
  input  logic [DEPTH-1:0]           valid,
  input  logic [DEPTH*TAG_WIDTH-1:0] tags,
  input  logic [DEPTH_WIDTH-1:0]     oldest,
  input  logic [TAG_WIDTH-1:0]       addr,
  output logic                       hit,
  output logic [DEPTH_WIDTH-1:0]     idx
);

  logic [DEPTH_WIDTH-1:0] slot;

  // Walk slots from the oldest position towards the youngest; later hits override earlier ones.
  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    slot = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = oldest + DEPTH_WIDTH'(k);
      if (valid[slot] && (tags[int'(slot)*TAG_WIDTH +: TAG_WIDTH] == addr)) begin
        hit = 1'b1;
        idx = slot;
      end
    end
  end

endmodule

// File: rtl/victim_writeback_buffer.sv
// rtl/victim_writeback_buffer.sv - dirty line FIFO draining word-serial bursts to memory
module victim_writeback_buffer
  import vwb_pkg::*;
#(
  parameter int BLOCK_OFFSET_WIDTH = VWB_BLOCK_OFFSET_WIDTH,
  parameter int DEPTH              = 4,
  parameter int DEPTH_WIDTH        = 2
) (
  input  logic                                               clk,
  input  logic                                               rst_n,
  input  logic                                               i_push,
  input  logic [`ADDR_WIDTH-BLOCK_OFFSET_WIDTH-3:0]          i_push_addr,
  input  logic [`DATA_WIDTH*(1<<BLOCK_OFFSET_WIDTH)-1:0]     i_push_data,
  output logic                                               o_full,
  output logic                                               o_empty,
  input  logic [`ADDR_WIDTH-BLOCK_OFFSET_WIDTH-3:0]          i_snoop_addr,
  output logic                                               o_snoop_hit,
  output logic [`DATA_WIDTH*(1<<BLOCK_OFFSET_WIDTH)-1:0]     o_snoop_data,
  output logic                                               o_mem_valid,
  output logic [`ADDR_WIDTH-1:0]                             o_mem_addr,
  output logic [`DATA_WIDTH-1:0]                             o_mem_data,
  output logic                                               o_mem_last,
  input  logic                                               i_mem_ready
);

  localparam int LINE_SIZE = vwb_line_size(BLOCK_OFFSET_WIDTH);
  localparam int LAW       = `ADDR_WIDTH - BLOCK_OFFSET_WIDTH - 2;
  localparam int DW        = `DATA_WIDTH;
  localparam int LINE_W    = DW * LINE_SIZE;

  logic [DEPTH-1:0]              valid_q;
  logic [LAW-1:0]                addr_q [DEPTH];
  logic [LINE_W-1:0]             data_q [DEPTH];
  logic [DEPTH_WIDTH-1:0]        head_q, tail_q;
  logic [DEPTH_WIDTH:0]          count_q, count_next;
  logic [BLOCK_OFFSET_WIDTH-1:0] beat_q;
  vwb_state_t                    state_q, state_next;

  logic [DEPTH*LAW-1:0]   tags_flat;
  logic [DEPTH-1:0]       head_onehot, coal_valid;
  logic                   snoop_hit, coal_hit;
  logic [DEPTH_WIDTH-1:0] snoop_idx, coal_idx;
  logic                   beat_last, mem_fire, do_pop, do_append, do_coalesce;

  // Flatten tags for the match units; hide the in-flight head from coalescing so its burst stays intact.
  always_comb begin
    tags_flat   = '0;
    head_onehot = '0;
    for (int i = 0; i < DEPTH; i++) begin
      tags_flat[i*LAW +: LAW] = addr_q[i];
      head_onehot[i]          = (head_q == DEPTH_WIDTH'(i));
    end
    coal_valid = valid_q & ~((state_q == VWB_SEND) ? head_onehot : '0);
  end

  vwb_match_unit #(.DEPTH(DEPTH), .DEPTH_WIDTH(DEPTH_WIDTH), .TAG_WIDTH(LAW)) u_snoop_match (
    .valid (valid_q),
    .tags  (tags_flat),
    .oldest(tail_q),
    .addr  (i_snoop_addr),
    .hit   (snoop_hit),
    .idx   (snoop_idx)
  );

  vwb_match_unit #(.DEPTH(DEPTH), .DEPTH_WIDTH(DEPTH_WIDTH), .TAG_WIDTH(LAW)) u_coal_match (
    .valid (coal_valid),
    .tags  (tags_flat),
    .oldest(tail_q),
    .addr  (i_push_addr),
    .hit   (coal_hit),
    .idx   (coal_idx)
  );

  assign o_snoop_hit  = snoop_hit;
  assign o_snoop_data = snoop_hit ? data_q[snoop_idx] : '0;

  assign o_full      = (count_q == (DEPTH_WIDTH+1)'(DEPTH));
  assign o_empty     = (count_q == '0) && (state_q == VWB_IDLE);
  assign beat_last   = (beat_q == BLOCK_OFFSET_WIDTH'(LINE_SIZE-1));
  assign o_mem_valid = (state_q == VWB_SEND);
  assign o_mem_last  = o_mem_valid && beat_last;
  assign o_mem_addr  = {addr_q[head_q], beat_q, 2'b00};
  assign o_mem_data  = data_q[head_q][int'(beat_q)*DW +: DW];

  assign mem_fire    = o_mem_valid && i_mem_ready;
  assign do_pop      = mem_fire && beat_last;
  assign do_coalesce = i_push && coal_hit;
  assign do_append   = i_push && !coal_hit && !o_full;
  assign count_next  = count_q + (DEPTH_WIDTH+1)'(do_append) - (DEPTH_WIDTH+1)'(do_pop);

  // Next-state: start a burst whenever lines are queued; leave SEND only when the last line pops.
  always_comb begin
    state_next = state_q;
    case (state_q)
      VWB_IDLE: if (count_q != '0) state_next = VWB_SEND;
      VWB_SEND: if (do_pop && (count_next == '0)) state_next = VWB_IDLE;
      default:  state_next = VWB_IDLE;
    endcase
  end

  // Control state: FSM, beat counter, pointers, occupancy and entry valid bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= VWB_IDLE;
      beat_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_next;
      count_q <= count_next;
      if (mem_fire) beat_q <= beat_last ? '0 : beat_q + BLOCK_OFFSET_WIDTH'(1);
      if (do_pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + DEPTH_WIDTH'(1);
      end
      if (do_append) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + DEPTH_WIDTH'(1);
      end
    end
  end

  // Line storage: append at tail, or overwrite a matching queued line in place.
  always_ff @(posedge clk) begin
    if (do_append) begin
      addr_q[tail_q] <= i_push_addr;
      data_q[tail_q] <= i_push_data;
    end else if (do_coalesce) begin
      data_q[coal_idx] <= i_push_data;
    end
  end

endmodule
